// File: rtl/regfile_2r1w_clr_pkg.sv
// rtl/regfile_2r1w_clr_pkg.sv - shared constants and clear-FSM state encoding for the register file
// Purpose: default widths and the IDLE/SWEEP state type used by the clear engine.
package regfile_2r1w_clr_pkg;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - sequential clear engine that zeroes every array location
// Purpose: walks a counter over all DEPTH addresses, one per clock, after reset
//          (if enabled) or on a clear request accepted while idle.
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset; aborts any sweep in progress
//   i_clr_req  in   clear request pulse, only honoured in IDLE
//   o_busy     out  sweep in progress
//   o_clr_en   out  write strobe for the sweep
//   o_clr_addr out  address being cleared this cycle
module regfile_clr_fsm
    import regfile_2r1w_clr_pkg::*;
#(
    parameter int ADDR_W         = RF_ADDR_W_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam int               DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  CNT_LAST    = (ADDR_W + 1)'(DEPTH - 1);
    localparam rf_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? RF_SWEEP : RF_IDLE;

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = RF_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            RF_SWEEP: begin
                // clr_req is deliberately not looked at here: a sweep is never restarted
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RF_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RF_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy     = (r_state == RF_SWEEP);
        o_clr_en   = (r_state == RF_SWEEP);
        o_clr_addr = r_cnt[ADDR_W-1:0];
    end

endmodule

// File: rtl/regfile_2r1w_clr.sv
// rtl/regfile_2r1w_clr.sv - 2-read 1-write register file with built-in clear sweep
// Purpose: CPU register file with selectable combinational/registered read,
//          optional write-to-read bypass and optional hardwired-zero location 0.
// Ports:
//   clk, resetn       clock and asynchronous active-low reset
//   we/waddr/wdata    user write port (ignored while busy)
//   raddr1/rdata1     read port 1
//   raddr2/rdata2     read port 2
//   clr_req           request a full clear (accepted only when idle)
//   busy              clear sweep in progress
module regfile_2r1w_clr
    import regfile_2r1w_clr_pkg::*;
#(
    parameter int DATA_W         = RF_DATA_W_DEF,
    parameter int ADDR_W         = RF_ADDR_W_DEF,
    parameter int ZERO_REG       = 1,
    parameter int READ_REG       = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              w_busy;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_sel   [2];

    regfile_clr_fsm #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_fsm (
        .clk        (clk),
        .resetn     (resetn),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    assign busy = w_busy;

    // Sweep owns the write port while it runs, so user writes are dropped then.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = waddr;
        w_mem_wdata = wdata;
        if (w_clr_en) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = w_clr_addr;
            w_mem_wdata = '0;
        end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
            w_mem_we = 1'b1;
        end
    end

    // Array has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_sel[p] = r_mem[w_raddr[p]];
            if (w_busy) begin
                w_sel[p] = '0;
            end else if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
                w_sel[p] = '0;
            end else if ((BYPASS != 0) && we && (waddr == w_raddr[p])) begin
                w_sel[p] = wdata;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] r_rdata [2];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_rdata[0] <= '0;
                    r_rdata[1] <= '0;
                end else begin
                    r_rdata[0] <= w_sel[0];
                    r_rdata[1] <= w_sel[1];
                end
            end

            assign rdata1 = r_rdata[0];
            assign rdata2 = r_rdata[1];
        end else begin : g_rd_comb
            assign rdata1 = w_sel[0];
            assign rdata2 = w_sel[1];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb/tb_regfile_2r1w_clr.sv - scoreboard bench for three register file configurations
module tb_regfile_2r1w_clr;

    // inst 0: comb read, bypass, zero reg
    // inst 1: registered read, no bypass, no zero reg
    // inst 2: comb read, no bypass, zero reg
    logic        clk = 1'b0;
    logic        resetn;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        clr_req;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .READ_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_a), .raddr2(raddr2), .rdata2(rd2_a),
        .clr_req(clr_req), .busy(busy_a));

    regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .READ_REG(1), .BYPASS(0), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
        .clr_req(clr_req), .busy(busy_b));

    regfile_2r1w_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .READ_REG(0), .BYPASS(0), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_c), .raddr2(raddr2), .rdata2(rd2_c),
        .clr_req(clr_req), .busy(busy_c));

    typedef struct {
        int          due;
        int          inst;
        int          port;
        logic [31:0] expv;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  cyc     = 0;
    int  n_cmp   = 0;
    int  n_fail  = 0;

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] actual(input int inst, input int port);
        logic [31:0] v;
        v = 'x;
        case (inst)
            0: v = (port == 0) ? rd1_a : (port == 1) ? rd2_a : {31'b0, busy_a};
            1: v = (port == 0) ? rd1_b : (port == 1) ? rd2_b : {31'b0, busy_b};
            default: v = (port == 0) ? rd1_c : (port == 1) ? rd2_c : {31'b0, busy_c};
        endcase
        return v;
    endfunction

    task automatic push(input int inst, input int port, input logic [31:0] e, input int due, input string tag);
        sb_t s;
        s.due  = due;
        s.inst = inst;
        s.port = port;
        s.expv = e;
        s.tag  = tag;
        sb_q.push_back(s);
    endtask

    // Comb instances are checked this cycle, the registered one a cycle later.
    task automatic expect_rd(input int port, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [31:0] ec, input string tag);
        push(0, port, ea, cyc, tag);
        push(1, port, eb, cyc + 1, tag);
        push(2, port, ec, cyc, tag);
    endtask

    task automatic expect_busy(input logic b, input string tag);
        for (int i = 0; i < 3; i++) push(i, 2, {31'b0, b}, cyc, tag);
    endtask

    task automatic check_due();
        sb_t keep[$];
        logic [31:0] act;
        foreach (sb_q[i]) begin
            if (sb_q[i].due == cyc) begin
                act = actual(sb_q[i].inst, sb_q[i].port);
                n_cmp++;
                assert (act === sb_q[i].expv) else begin
                    n_fail++;
                    $error("FAIL %s cyc=%0d inst=%0d port=%0d observed=%h expected=%h",
                           sb_q[i].tag, cyc, sb_q[i].inst, sb_q[i].port, act, sb_q[i].expv);
                end
            end else begin
                keep.push_back(sb_q[i]);
            end
        end
        sb_q = keep;
    endtask

    task automatic tick();
        @(negedge clk);
        check_due();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic busy_window(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            raddr1 = 5'd31;
            raddr2 = 5'(i);
            expect_busy(1'b1, tag);
            expect_rd(0, 32'h0, 32'h0, 32'h0, tag);
            expect_rd(1, 32'h0, 32'h0, 32'h0, tag);
            tick();
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            expect_busy(1'b0, tag);
            expect_rd(0, 32'h0, 32'h0, 32'h0, tag);
            expect_rd(1, 32'h0, 32'h0, 32'h0, tag);
            tick();
        end
    endtask

    task automatic fill(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            we    = 1'b1;
            waddr = 5'(a);
            wdata = pat(a);
            tick();
        end
        we = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr1  = 5'd3;
        raddr2  = 5'd4;
        clr_req = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        for (int i = 0; i < 3; i++) begin
            expect_busy(1'b1, "reset_busy");
            expect_rd(0, 32'h0, 32'h0, 32'h0, "reset_rd1");
            expect_rd(1, 32'h0, 32'h0, 32'h0, "reset_rd2");
            tick();
        end

        // clear-on-reset sweep: exactly 32 busy cycles, then all zero
        resetn = 1'b1;
        busy_window(32, "por_sweep");
        read_all_zero("por_zero");

        // write then read, with same-cycle bypass on port 1
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd9;
        expect_rd(0, 32'hDEAD_BEEF, 32'h0, 32'h0, "wr5_same");
        expect_rd(1, 32'h0, 32'h0, 32'h0, "wr5_other");
        tick();
        we = 1'b0;
        expect_rd(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd5_next");
        tick();

        // bypass on port 2
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_1234; raddr2 = 5'd7;
        expect_rd(1, 32'h0000_1234, 32'h0, 32'h0, "byp7_same");
        expect_rd(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "byp7_p1");
        tick();
        we = 1'b0;
        expect_rd(1, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, "rd7_next");
        tick();

        // address 0: hardwired zero vs ordinary location
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        expect_rd(0, 32'h0, 32'h0, 32'h0, "zero_same");
        tick();
        we = 1'b0;
        expect_rd(0, 32'h0, 32'hFFFF_FFFF, 32'h0, "zero_next");
        tick();

        // fill 1..31, verify, then clear with a dropped write and an ignored re-request
        fill(1, 31);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a);
            expect_rd(0, (a == 0) ? 32'h0 : pat(a), (a == 0) ? 32'hFFFF_FFFF : pat(a), (a == 0) ? 32'h0 : pat(a), "fill_rd1");
            expect_rd(1, (a == 0) ? 32'h0 : pat(a), (a == 0) ? 32'hFFFF_FFFF : pat(a), (a == 0) ? 32'h0 : pat(a), "fill_rd2");
            tick();
        end
        clr_req = 1'b1;
        raddr1  = 5'd31;
        expect_busy(1'b0, "clr_accept");
        expect_rd(0, pat(31), pat(31), pat(31), "clr_accept_rd");
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1  = 5'd31;
            raddr2  = 5'(i);
            we      = (i == 10);
            waddr   = 5'd3;
            wdata   = 32'hBAD0_BAD0;
            clr_req = (i == 20);
            expect_busy(1'b1, "clr_busy");
            expect_rd(0, 32'h0, 32'h0, 32'h0, "clr_rd1");
            expect_rd(1, 32'h0, 32'h0, 32'h0, "clr_rd2");
            tick();
        end
        we      = 1'b0;
        clr_req = 1'b0;
        read_all_zero("clr_zero");

        // reset in the middle of a sweep restarts a full sweep
        fill(20, 31);
        clr_req = 1'b1;
        expect_busy(1'b0, "rst_clr_accept");
        tick();
        clr_req = 1'b0;
        busy_window(10, "pre_abort");
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_busy(1'b1, "abort_busy");
            expect_rd(0, 32'h0, 32'h0, 32'h0, "abort_rd1");
            tick();
        end
        resetn = 1'b1;
        busy_window(32, "restart_sweep");
        read_all_zero("restart_zero");

        tick();
        tick();
        n_cmp++;
        assert (sb_q.size() === 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
